// File: rtl/serial_twos_comp_rx.sv
// serial_twos_comp_rx: LSB-first serial word receiver giving raw value plus sign/magnitude via serial negation
module serial_twos_comp_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y_raw,
  output logic [WIDTH-1:0] y_mag,
  output logic             y_sign,
  output logic             y_valid,
  output logic             frame_err
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [IW-1:0] count, count_n;
  logic seen_one, seen_one_n, done, err;
  logic [WIDTH-1:0] raw, raw_n, neg, neg_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      seen_one <= 1'b0;
      raw <= '0;
      neg <= '0;
      y_raw <= '0;
      y_mag <= '0;
      y_sign <= 1'b0;
      y_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      seen_one <= seen_one_n;
      raw <= raw_n;
      neg <= neg_n;
      y_valid <= done;
      frame_err <= err;
      if (done) begin
        y_raw <= raw_n;
        y_sign <= x;
        y_mag <= x ? neg_n : raw_n;
      end
    end
  end
  always_comb begin
    state_n = state;
    count_n = count;
    seen_one_n = seen_one;
    raw_n = raw;
    neg_n = neg;
    done = 1'b0;
    err = 1'b0;
    if (x_valid && sof) begin
      err = state == SHIFT;
      raw_n = {{(WIDTH-1){1'b0}}, x};
      neg_n = {{(WIDTH-1){1'b0}}, x};
      seen_one_n = x;
      count_n = IW'(1);
      state_n = SHIFT;
    end else if (x_valid && state == SHIFT) begin
      raw_n[count] = x;
      neg_n[count] = seen_one ? ~x : x;
      seen_one_n = seen_one | x;
      done = count == IW'(WIDTH-1);
      count_n = done ? '0 : count + 1'b1;
      state_n = done ? IDLE : SHIFT;
    end
  end
endmodule

// File: tb/tb_serial_twos_comp_rx.sv
// tb_serial_twos_comp_rx: randomized scoreboard bench for serial_twos_comp_rx
module tb_serial_twos_comp_rx;
  localparam int W = 8;
  logic clk = 0, reset = 1, x = 0, x_valid = 0, sof = 0;
  logic [W-1:0] y_raw, y_mag;
  logic y_sign, y_valid, frame_err;
  serial_twos_comp_rx #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .sof(sof),
    .y_raw(y_raw), .y_mag(y_mag), .y_sign(y_sign), .y_valid(y_valid), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  typedef struct {int due; logic [W-1:0] raw, mag; logic sign;} exp_t;
  exp_t q[$];
  int eq[$];
  int cyc = 0, checks = 0, errors = 0;
  bit mon_en = 0, in_word = 0;
  logic [W-1:0] cur_raw = 0, cur_mag = 0;
  logic cur_sign = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      q.delete();
      eq.delete();
      cur_raw <= 0;
      cur_mag <= 0;
      cur_sign <= 0;
    end
  end
  always @(negedge clk) if (mon_en) begin
    bit ev, ee;
    ev = q.size() > 0 && q[0].due == cyc;
    chk("y_valid", 32'(y_valid), 32'(ev));
    if (ev) begin
      cur_raw = q[0].raw;
      cur_mag = q[0].mag;
      cur_sign = q[0].sign;
      void'(q.pop_front());
    end
    chk("y_raw", 32'(y_raw), 32'(cur_raw));
    chk("y_mag", 32'(y_mag), 32'(cur_mag));
    chk("y_sign", 32'(y_sign), 32'(cur_sign));
    ee = eq.size() > 0 && eq[0] == cyc;
    chk("frame_err", 32'(frame_err), 32'(ee));
    if (ee) void'(eq.pop_front());
  end
  task automatic drive(logic v, logic s, logic b);
    @(posedge clk);
    #1;
    x_valid = v;
    sof = s;
    x = b;
  endtask
  task automatic send_bits(logic [W-1:0] w, int n, int gmax);
    for (int i = 0; i < n; i++) begin
      bit prev;
      if (i > 0) repeat ($urandom_range(gmax, 0)) drive(1'b0, 1'($urandom), 1'($urandom));
      prev = in_word;
      drive(1'b1, i == 0, w[i]);
      if (i == 0 && prev) eq.push_back(cyc + 1);
      in_word = i != W - 1;
      if (i == W - 1) begin
        exp_t e;
        e.due = cyc + 1;
        e.raw = w;
        e.sign = w[W-1];
        e.mag = w[W-1] ? W'((1 << W) - int'(w)) : w;
        q.push_back(e);
      end
    end
  endtask
  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'($urandom), 1'($urandom));
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1;
    x_valid = 0;
    @(posedge clk);
    #1;
    reset = 0;
    in_word = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    mon_en = 1;
    idle(2);
    send_bits(8'hFA, W, 0);
    idle(3);
    send_bits(8'h05, W, 0);
    send_bits(8'h80, W, 0);
    send_bits(8'h00, W, 0);
    idle(2);
    send_bits(8'h9C, W, 3);
    idle(2);
    send_bits(8'hFF, 4, 0);
    send_bits(8'h7F, W, 0);
    idle(2);
    send_bits(8'h81, 5, 0);
    do_reset();
    for (int i = 5; i < W; i++) drive(1'b1, 1'b0, 1'(8'h81 >> i));
    send_bits(8'hFE, W, 1);
    idle(2);
    repeat (10) drive(1'b1, 1'b0, 1'b1);
    idle(2);
    for (int k = 0; k < 250; k++) begin
      int r;
      r = $urandom_range(9, 0);
      if (r == 0) send_bits(W'($urandom), $urandom_range(W - 1, 1), $urandom_range(2, 0));
      else if (r == 1) begin
        send_bits(W'($urandom), $urandom_range(W - 1, 1), 1);
        do_reset();
      end else send_bits(W'($urandom), W, $urandom_range(3, 0));
      if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 0));
    end
    idle(4);
    chk("drain_valid", 32'(q.size()), 32'd0);
    chk("drain_err", 32'(eq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
